// File: rtl/wb_master_pkg.sv
// rtl/wb_master_pkg.sv - shared state encoding and defaults for the Wishbone command master
package wb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RSP  = 2'd2
    } wb_state_t;

    localparam logic [31:0] ERR_READ_VALUE_DEF = 32'hBAD_FAB_AC;

endpackage

// File: rtl/wb_timeout_cntr.sv
// rtl/wb_timeout_cntr.sv - bus-phase cycle counter flagging when the ACK wait limit is reached
module wb_timeout_cntr #(
    parameter int TIMEOUT_CYCLES = 255,
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic inc,
    output logic expired
);

    logic [CW-1:0] count;

    // Loaded with 1 at accept so the value equals the current bus-phase cycle number
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (start) begin
            count <= CW'(1);
        end else if (inc) begin
            count <= count + 1'b1;
        end else begin
            count <= '0;
        end
    end

    assign expired = (count == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - single-outstanding command/response to Wishbone initiator with ACK timeout
module wb_cmd_master
    import wb_master_pkg::*;
#(
    parameter int          ADDRWIDTH      = 17,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_READ_VALUE = ERR_READ_VALUE_DEF
) (
    input  logic                 WB_CLK,
    input  logic                 WB_RST_n,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [ADDRWIDTH-1:0] cmd_adr_i,
    input  logic                 cmd_we_i,
    input  logic [3:0]           cmd_byte_stb_i,
    input  logic [31:0]          cmd_dat_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_dat_o,
    output logic                 rsp_err_o,
    output logic [ADDRWIDTH-1:0] WBs_ADR,
    output logic                 WBs_CYC,
    output logic                 WBs_STB,
    output logic                 WBs_WE,
    output logic                 WBs_RD,
    output logic [3:0]           WBs_BYTE_STB,
    output logic [31:0]          WBs_WR_DAT,
    input  logic [31:0]          WBs_RD_DAT,
    input  logic                 WBs_ACK
);

    wb_state_t state;
    logic      accept;
    logic      expired;

    assign cmd_ready_o = (state == ST_IDLE);
    assign accept      = cmd_valid_i && cmd_ready_o;

    wb_timeout_cntr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (WB_CLK),
        .rst_n  (WB_RST_n),
        .start  (accept),
        .inc    (state == ST_BUS),
        .expired(expired)
    );

    // The Wishbone output registers double as the latched command for the whole bus phase
    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            state        <= ST_IDLE;
            WBs_ADR      <= '0;
            WBs_CYC      <= 1'b0;
            WBs_STB      <= 1'b0;
            WBs_WE       <= 1'b0;
            WBs_RD       <= 1'b0;
            WBs_BYTE_STB <= 4'h0;
            WBs_WR_DAT   <= 32'h0;
            rsp_valid_o  <= 1'b0;
            rsp_err_o    <= 1'b0;
            rsp_dat_o    <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state        <= ST_BUS;
                        WBs_ADR      <= cmd_adr_i;
                        WBs_CYC      <= 1'b1;
                        WBs_STB      <= 1'b1;
                        WBs_WE       <= cmd_we_i;
                        WBs_RD       <= ~cmd_we_i;
                        WBs_BYTE_STB <= cmd_byte_stb_i;
                        WBs_WR_DAT   <= cmd_we_i ? cmd_dat_i : 32'h0;
                    end
                end
                ST_BUS: begin
                    if (WBs_ACK || expired) begin
                        state        <= ST_RSP;
                        WBs_ADR      <= '0;
                        WBs_CYC      <= 1'b0;
                        WBs_STB      <= 1'b0;
                        WBs_WE       <= 1'b0;
                        WBs_RD       <= 1'b0;
                        WBs_BYTE_STB <= 4'h0;
                        WBs_WR_DAT   <= 32'h0;
                        rsp_valid_o  <= 1'b1;
                        // An ACK on the final allowed cycle still wins over the timeout
                        if (WBs_ACK) begin
                            rsp_err_o <= 1'b0;
                            rsp_dat_o <= WBs_WE ? 32'h0 : WBs_RD_DAT;
                        end else begin
                            rsp_err_o <= 1'b1;
                            rsp_dat_o <= ERR_READ_VALUE;
                        end
                    end
                end
                ST_RSP: begin
                    if (rsp_ready_i) begin
                        state       <= ST_IDLE;
                        rsp_valid_o <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
